// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one line-granular memory bus between the I-cache (port 0)
// and the D-cache (port 1). One transaction in flight at a time, with a bounded load wait.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned LINE_WIDTH     = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_store,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*LINE_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [LINE_WIDTH-1:0]   resp_data,
  output logic                    resp_err,
  output logic                    mem_cmd_valid,
  output logic                    mem_cmd_store,
  output logic [ADDR_WIDTH-1:0]   mem_cmd_addr,
  output logic [LINE_WIDTH-1:0]   mem_cmd_wdata,
  input  logic                    mem_cmd_ready,
  input  logic                    mem_resp_valid,
  input  logic [LINE_WIDTH-1:0]   mem_resp_data,
  output logic                    err_sticky
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWaitResp, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    rr_last_q, rr_last_d;
  logic                    owner_q, owner_d;
  logic                    store_q, store_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic grant_port;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_port = ~rr_last_q;
    end else begin
      grant_port = req_valid[1];
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    owner_d       = owner_q;
    store_d       = store_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    err_sticky_d  = err_sticky_q;
    cnt_d         = cnt_q;
    req_ready     = 2'b00;
    resp_valid    = 2'b00;
    resp_data     = '0;
    resp_err      = 1'b0;
    mem_cmd_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready[grant_port] = 1'b1;
          owner_d   = grant_port;
          rr_last_d = grant_port;
          store_d   = req_store[grant_port];
          addr_d    = grant_port ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : req_addr[ADDR_WIDTH-1:0];
          wdata_d   = grant_port ? req_wdata[2*LINE_WIDTH-1:LINE_WIDTH]
                                 : req_wdata[LINE_WIDTH-1:0];
          state_d   = StCmd;
        end
      end
      StCmd: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) begin
          if (store_q) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = StResp;
          end else begin
            cnt_d   = '0;
            state_d = StWaitResp;
          end
        end
      end
      StWaitResp: begin
        // A response arriving on the limit cycle still counts as a normal completion.
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLimit) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          err_sticky_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        resp_valid[owner_q] = 1'b1;
        resp_data           = rdata_q;
        resp_err            = err_q;
        if (resp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_cmd_store = store_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_wdata = wdata_q;
  assign err_sticky    = err_sticky_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_last_q    <= 1'b1;
      owner_q      <= 1'b0;
      store_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule
